// File: rtl/sym_round_ctrl.sv
// Round controller for the symbol game: gates the generator for a programmed
// number of clocks, tallies target/total symbols, then scores the player's guess.
module sym_round_ctrl #(
  parameter int SYM_W = 8,
  parameter int CNT_W = 8
) (
  input  logic             Clk100M,
  input  logic             reset,
  input  logic             start,
  input  logic [SYM_W-1:0] targetSym,
  input  logic [31:0]      gameCycles,
  input  logic             generated,
  input  logic [SYM_W-1:0] generatedSym,
  input  logic             guessValid,
  input  logic [CNT_W-1:0] guess,
  output logic             genSym,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] matchCount,
  output logic [CNT_W-1:0] totalCount,
  output logic             resultValid,
  output logic             win,
  output logic [CNT_W-1:0] diff
);

  // state  | meaning
  // IDLE   | waiting for start, generator disabled
  // PLAY   | genSym high, timer counting down, tallying symbols
  // DRAIN  | one clock to catch a pulse launched on the last PLAY cycle
  // GUESS  | counters frozen, waiting for the player's guess
  // RESULT | win/diff held until the next start
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PLAY   = 3'd1,
    S_DRAIN  = 3'd2,
    S_GUESS  = 3'd3,
    S_RESULT = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic [31:0]      timer_q;
  logic [SYM_W-1:0] target_q;
  logic [CNT_W-1:0] match_q, total_q, diff_q;
  logic             gen_sym_q, result_valid_q, win_q;

  logic             start_ok;
  logic             tally_en;
  logic [CNT_W-1:0] guess_diff;

  always_comb begin
    start_ok   = 1'b0;
    tally_en   = 1'b0;
    guess_diff = '0;
    start_ok   = start && (state_q == S_IDLE || state_q == S_RESULT);
    tally_en   = generated && (state_q == S_PLAY || state_q == S_DRAIN);
    guess_diff = (guess >= match_q) ? (guess - match_q) : (match_q - guess);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_RESULT: if (start) state_d = S_PLAY;
      S_PLAY:           if (timer_q <= 32'd1) state_d = S_DRAIN;
      S_DRAIN:          state_d = S_GUESS;
      S_GUESS:          if (guessValid) state_d = S_RESULT;
      default:          state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk100M) begin
    if (reset) begin
      state_q        <= S_IDLE;
      gen_sym_q      <= 1'b0;
      timer_q        <= '0;
      target_q       <= '0;
      match_q        <= '0;
      total_q        <= '0;
      result_valid_q <= 1'b0;
      win_q          <= 1'b0;
      diff_q         <= '0;
    end else begin
      state_q   <= state_d;
      gen_sym_q <= (state_d == S_PLAY);
      if (start_ok) begin
        // A zero play length still gives the generator one enabled clock.
        target_q       <= targetSym;
        timer_q        <= (gameCycles == 32'd0) ? 32'd1 : gameCycles;
        match_q        <= '0;
        total_q        <= '0;
        result_valid_q <= 1'b0;
        win_q          <= 1'b0;
        diff_q         <= '0;
      end else begin
        if (state_q == S_PLAY) timer_q <= timer_q - 32'd1;
        if (tally_en) begin
          if (total_q != CNT_MAX) total_q <= total_q + 1'b1;
          if (generatedSym == target_q && match_q != CNT_MAX)
            match_q <= match_q + 1'b1;
        end
        if (state_q == S_GUESS && guessValid) begin
          result_valid_q <= 1'b1;
          win_q          <= (guess == match_q);
          diff_q         <= guess_diff;
        end
      end
    end
  end

  assign genSym      = gen_sym_q;
  assign state       = state_q;
  assign matchCount  = match_q;
  assign totalCount  = total_q;
  assign resultValid = result_valid_q;
  assign win         = win_q;
  assign diff        = diff_q;

endmodule
